// File: rtl/mig_line_ctrl.sv
// mig_line_ctrl: moves one cache line between a CPU-side request port and a
// Xilinx MIG user interface. Each line is LINE_BEATS beats of APP_DATA_W bits.
//
// Ports
//   ui_clk, rst (sync, active-low)     clock / reset
//   init_calib_complete, busy          MIG calibration status / controller busy
//   req_*                              CPU request: line index, write data, byte enables
//   rsp_valid, rsp_rdata               one-cycle completion pulse / last read line
//   app_en/cmd/addr/rdy                MIG command channel
//   app_wdf_*                          MIG write-data channel
//   app_rd_data, app_rd_data_valid     MIG read-data channel
//
// Optional feature macro: LAST_LINE_BYPASS_EN. When defined, a read of the
// line most recently read from memory completes without touching the MIG and
// returns the held rsp_rdata.
//
// state | meaning
// IDLE  | waiting for a request (only when calibration is complete)
// WRITE | issuing write commands and write-data beats independently
// READ  | issuing read commands and collecting returned beats
// DONE  | one-cycle rsp_valid, then back to IDLE

module mig_line_ctrl #(
    parameter int LINE_BEATS  = 2,
    parameter int APP_DATA_W  = 128,
    parameter int APP_ADDR_W  = 27,
    parameter int BEAT_STRIDE = 16
) (
    input  logic                                                    ui_clk,
    input  logic                                                    rst,
    input  logic                                                    init_calib_complete,
    output logic                                                    busy,
    input  logic                                                    req_valid,
    output logic                                                    req_ready,
    input  logic                                                    req_write,
    input  logic [APP_ADDR_W-$clog2(LINE_BEATS*BEAT_STRIDE)-1:0]    req_line,
    input  logic [LINE_BEATS*APP_DATA_W-1:0]                        req_wdata,
    input  logic [LINE_BEATS*APP_DATA_W/8-1:0]                      req_wmask,
    output logic                                                    rsp_valid,
    output logic [LINE_BEATS*APP_DATA_W-1:0]                        rsp_rdata,
    output logic                                                    app_en,
    output logic [2:0]                                              app_cmd,
    output logic [APP_ADDR_W-1:0]                                   app_addr,
    input  logic                                                    app_rdy,
    output logic                                                    app_wdf_wren,
    output logic                                                    app_wdf_end,
    output logic [APP_DATA_W-1:0]                                   app_wdf_data,
    output logic [APP_DATA_W/8-1:0]                                 app_wdf_mask,
    input  logic                                                    app_wdf_rdy,
    input  logic [APP_DATA_W-1:0]                                   app_rd_data,
    input  logic                                                    app_rd_data_valid
);

    localparam int LINE_SHIFT   = $clog2(LINE_BEATS*BEAT_STRIDE);
    localparam int LINE_W       = APP_ADDR_W - LINE_SHIFT;
    localparam int STRIDE_SHIFT = $clog2(BEAT_STRIDE);
    localparam int MASK_W       = APP_DATA_W/8;
    localparam int CNT_W        = $clog2(LINE_BEATS+1);
    localparam logic [CNT_W-1:0] BEATS = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(LINE_BEATS-1);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

    state_t                          r_state;
    logic [CNT_W-1:0]                r_cmd_cnt;
    logic [CNT_W-1:0]                r_wdat_cnt;
    logic [CNT_W-1:0]                r_rdat_cnt;
    logic [LINE_W-1:0]               r_line;
    logic [LINE_BEATS*APP_DATA_W-1:0] r_wdata;
    logic [LINE_BEATS*MASK_W-1:0]    r_wmask;
    logic [LINE_BEATS*APP_DATA_W-1:0] r_rdata;

    logic                            w_accept;
    logic                            w_cmd_fire;
    logic                            w_wdf_fire;
    logic                            w_rd_fire;
    logic                            w_bypass;
    logic [CNT_W-1:0]                w_cmd_nxt;
    logic [CNT_W-1:0]                w_wdat_nxt;
    logic [APP_DATA_W-1:0]           w_wbeat;
    logic [MASK_W-1:0]               w_wmask_beat;

    assign req_ready    = (r_state == S_IDLE) && init_calib_complete;
    assign w_accept     = req_valid && req_ready;
    assign busy         = (r_state != S_IDLE);
    assign rsp_valid    = (r_state == S_DONE);
    assign rsp_rdata    = r_rdata;

    assign app_en       = ((r_state == S_WRITE) || (r_state == S_READ)) && (r_cmd_cnt < BEATS) && !w_bypass;
    assign app_cmd      = (r_state == S_WRITE) ? 3'b000 : 3'b001;
    assign app_addr     = (APP_ADDR_W'(r_line) << LINE_SHIFT) + (APP_ADDR_W'(r_cmd_cnt) << STRIDE_SHIFT);

    assign app_wdf_wren = (r_state == S_WRITE) && (r_wdat_cnt < BEATS);
    assign app_wdf_end  = app_wdf_wren;
    assign app_wdf_data = w_wbeat;
    assign app_wdf_mask = ~w_wmask_beat;

    assign w_cmd_fire   = app_en && app_rdy;
    assign w_wdf_fire   = app_wdf_wren && app_wdf_rdy;
    assign w_rd_fire    = (r_state == S_READ) && app_rd_data_valid;
    assign w_cmd_nxt    = r_cmd_cnt + CNT_W'(w_cmd_fire);
    assign w_wdat_nxt   = r_wdat_cnt + CNT_W'(w_wdf_fire);

    always_comb begin
        w_wbeat      = '0;
        w_wmask_beat = '0;
        for (int b = 0; b < LINE_BEATS; b++) begin
            if (r_wdat_cnt == CNT_W'(b)) begin
                w_wbeat      = r_wdata[b*APP_DATA_W +: APP_DATA_W];
                w_wmask_beat = r_wmask[b*MASK_W +: MASK_W];
            end
        end
    end

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_cmd_cnt  <= '0;
            r_wdat_cnt <= '0;
            r_rdat_cnt <= '0;
            r_line     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_line     <= req_line;
                        r_wdata    <= req_wdata;
                        r_wmask    <= req_wmask;
                        r_cmd_cnt  <= '0;
                        r_wdat_cnt <= '0;
                        r_rdat_cnt <= '0;
                        r_state    <= req_write ? S_WRITE : S_READ;
                    end
                end
                S_WRITE: begin
                    r_cmd_cnt  <= w_cmd_nxt;
                    r_wdat_cnt <= w_wdat_nxt;
                    // Finish on the cycle the last of both handshakes completes.
                    if ((w_cmd_nxt == BEATS) && (w_wdat_nxt == BEATS)) begin
                        r_state <= S_DONE;
                    end
                end
                S_READ: begin
                    r_cmd_cnt <= w_cmd_nxt;
                    if (w_bypass) begin
                        r_state <= S_DONE;
                    end else if (w_rd_fire) begin
                        for (int b = 0; b < LINE_BEATS; b++) begin
                            if (r_rdat_cnt == CNT_W'(b)) begin
                                r_rdata[b*APP_DATA_W +: APP_DATA_W] <= app_rd_data;
                            end
                        end
                        r_rdat_cnt <= r_rdat_cnt + 1'b1;
                        if (r_rdat_cnt == LAST) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef LAST_LINE_BYPASS_EN
    logic              r_tag_valid;
    logic              r_hit;
    logic [LINE_W-1:0] r_tag;

    always_ff @(posedge ui_clk) begin
        if (!rst) begin
            r_tag_valid <= 1'b0;
            r_hit       <= 1'b0;
            r_tag       <= '0;
        end else begin
            if (w_accept) begin
                r_hit <= !req_write && r_tag_valid && (req_line == r_tag);
                if (req_write && (req_line == r_tag)) begin
                    r_tag_valid <= 1'b0;
                end
            end
            if (w_rd_fire && !r_hit && (r_rdat_cnt == LAST)) begin
                r_tag_valid <= 1'b1;
                r_tag       <= r_line;
            end
        end
    end

    // A hit still passes through READ for one cycle, with the MIG command
    // channel held off, so the answer keeps a fixed two-cycle latency.
    assign w_bypass = r_hit && (r_state == S_READ);
`else
    assign w_bypass = 1'b0;
`endif

endmodule

// File: doc/mig_line_ctrl.md
MIG_LINE_CTRL -- requirements
Module: mig_line_ctrl

Interface
REQ-001 SHALL have parameter LINE_BEATS, default 2, giving the number of APP_DATA_W beats per cache line (power of two, 1..8).
REQ-002 SHALL have parameter APP_DATA_W, default 128, giving the MIG user data width.
REQ-003 SHALL have parameter APP_ADDR_W, default 27, giving the MIG app_addr width.
REQ-004 SHALL have parameter BEAT_STRIDE, default 16, giving the app_addr increment per beat (power of two).
REQ-005 SHALL have ports ui_clk in 1 (sole clock) and rst in 1 (reset: synchronous, active-low).
REQ-006 SHALL have ports init_calib_complete in 1 and busy out 1 (high whenever state is not IDLE).
REQ-007 SHALL have CPU-side ports req_valid in 1, req_ready out 1, req_write in 1 and req_line in APP_ADDR_W-log2(LINE_BEATS*BEAT_STRIDE) (line index).
REQ-008 SHALL have CPU-side ports req_wdata in LINE_BEATS*APP_DATA_W, req_wmask in LINE_BEATS*APP_DATA_W/8 (1 = byte written), rsp_valid out 1 and rsp_rdata out LINE_BEATS*APP_DATA_W.
REQ-009 SHALL have MIG-side ports app_en out 1, app_cmd out 3, app_addr out APP_ADDR_W and app_rdy in 1.
REQ-010 SHALL have MIG-side ports app_wdf_wren out 1, app_wdf_end out 1, app_wdf_data out APP_DATA_W, app_wdf_mask out APP_DATA_W/8 and app_wdf_rdy in 1.
REQ-011 SHALL have MIG-side ports app_rd_data in APP_DATA_W and app_rd_data_valid in 1.

Function
REQ-012 SHALL implement states IDLE, WRITE, READ and DONE.
REQ-013 SHALL drive req_ready=1 only in IDLE with init_calib_complete=1; a request is accepted on req_valid&req_ready, and req_write/req_line/req_wdata/req_wmask are registered at acceptance.
REQ-014 SHALL enter WRITE or READ the cycle after acceptance and clear cmd_cnt, wdat_cnt and rdat_cnt.
REQ-015 SHALL drive app_en=1 in WRITE/READ while cmd_cnt<LINE_BEATS; a command is accepted on app_en&app_rdy, which increments cmd_cnt.
REQ-016 SHALL form app_addr as (line<<log2(LINE_BEATS*BEAT_STRIDE)) + cmd_cnt*BEAT_STRIDE, with app_cmd=3'b000 in WRITE and 3'b001 otherwise.
REQ-017 SHALL in WRITE assert app_wdf_wren while wdat_cnt<LINE_BEATS, independently of command progress; a beat is accepted on app_wdf_wren&app_wdf_rdy, which increments wdat_cnt.
REQ-018 SHALL drive app_wdf_data = beat wdat_cnt of the line (beat 0 = LSBs), app_wdf_mask = bitwise NOT of that beat's req_wmask slice, and app_wdf_end = app_wdf_wren.
REQ-019 SHALL leave WRITE for DONE once cmd_cnt==LINE_BEATS and wdat_cnt==LINE_BEATS.
REQ-020 SHALL in READ store app_rd_data into rsp_rdata beat rdat_cnt on each app_rd_data_valid, increment rdat_cnt, and move to DONE on the last beat, including when the last command and the first data arrive in the same cycle.
REQ-021 SHALL ignore app_rd_data_valid outside READ.
REQ-022 SHALL pulse rsp_valid for exactly one cycle in DONE, for both reads and writes, then return to IDLE; rsp_rdata SHALL hold its value until the next read beat is captured.
REQ-023 SHALL have a minimum latency from acceptance to rsp_valid of LINE_BEATS+1 cycles for a write with app_rdy=app_wdf_rdy=1.

Reset
REQ-024 SHALL, with rst=0 at a ui_clk edge, set state=IDLE, all counters to 0, app_en=app_wdf_wren=0, rsp_valid=0, busy=0 and rsp_rdata=0.
REQ-025 SHALL, when reset occurs mid-operation, abandon the operation with no rsp_valid, and ignore read data that arrives after the reset.

Configuration
REQ-026 SHALL, with LAST_LINE_BYPASS_EN defined, keep a valid flag and a tag holding the line of the last completed read.
REQ-027 SHALL, with LAST_LINE_BYPASS_EN defined, answer an accepted read whose line equals the tag while valid by going directly to DONE with no MIG command, leaving rsp_rdata unchanged.
REQ-028 SHALL, with LAST_LINE_BYPASS_EN defined, clear the valid flag on reset and on any accepted write to the tagged line.
REQ-029 SHALL, without LAST_LINE_BYPASS_EN, issue a MIG read for every read request and implement no tag logic.

Verification
REQ-030 SHALL cover: reset, then calib=1 and a write to line 3 with app_rdy=app_wdf_rdy=1 -> commands at app_addr 0x60 and 0x70, cmd 0, and rsp_valid 3 cycles after acceptance.
REQ-031 SHALL cover: a write with req_wmask beat 1 all-zero and app_wdf_rdy low for 4 cycles -> second beat app_wdf_mask=16'hFFFF, and DONE reached only after both counters reach 2.
REQ-032 SHALL cover: a read of line 5 with data returned as beat0=A and beat1=B three cycles apart -> rsp_rdata={B,A} with a single rsp_valid pulse.
REQ-033 SHALL cover: rst=0 while in READ after one data beat, then stray app_rd_data_valid -> no rsp_valid, state IDLE and rsp_rdata=0.
REQ-034 SHALL cover, with LAST_LINE_BYPASS_EN: read line 5, read line 5 again -> no app_en on the second read and rsp_valid 2 cycles after acceptance; then write line 5 and read line 5 -> MIG read issued.
REQ-035 SHALL cover: init_calib_complete=0 with req_valid=1 -> req_ready=0 and app_en=0 throughout.
